// File: rtl/amo_core_arbiter_pkg.sv
// Shared types and constants for the core-to-atomic-unit request arbiter.
package amo_core_arbiter_pkg;

  localparam int AMO_TYPE_W = 5;
  localparam int CLP        = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amo_core_arbiter_rr.sv
// Combinational round-robin pick: first set req bit after 'last', wrapping.
module rr_arbiter
  import amo_core_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int LW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt_onehot,
  output logic [LW-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/amo_core_arbiter.sv
// Shares one atomic-unit request port between N cores: per-core pending slots,
// round-robin grant, one transaction in flight, one idle cycle between strobes.
module amo_core_arbiter
  import amo_core_arbiter_pkg::*;
#(
  parameter int N      = 2,
  parameter int XLEN   = 32,
  parameter int CLSIZE = CLP
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N-1:0]             P_strobe_i,
  input  logic [N*XLEN-1:0]        P_addr_i,
  input  logic [N-1:0]             P_rw_i,
  input  logic [N*CLSIZE-1:0]      P_data_i,
  input  logic [N-1:0]             P_is_amo_i,
  input  logic [N*AMO_TYPE_W-1:0]  P_amo_type_i,
  output logic [N-1:0]             P_done_o,
  output logic [CLSIZE-1:0]        P_data_o,
  output logic [N-1:0]             core_id_o,
  output logic                     core_strobe_o,
  output logic [XLEN-1:0]          core_addr_o,
  output logic                     core_rw_o,
  output logic [CLSIZE-1:0]        core_data_o,
  output logic                     core_is_amo_o,
  output logic [AMO_TYPE_W-1:0]    core_amo_type_o,
  input  logic                     core_done_i,
  input  logic [CLSIZE-1:0]        core_data_i
);

  localparam int LW = idx_w(N);

  typedef struct packed {
    logic [XLEN-1:0]       addr;
    logic                  rw;
    logic [CLSIZE-1:0]     data;
    logic                  is_amo;
    logic [AMO_TYPE_W-1:0] amo_type;
  } req_t;

  req_t   [N-1:0]  slot;
  logic   [N-1:0]  pending, pick_oh, clr;
  logic   [LW-1:0] pick_idx, last_grant, g;
  state_e          state;

  rr_arbiter #(.N(N), .LW(LW)) u_rr (
    .req        (pending),
    .last       (last_grant),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx)
  );

  // core_id_o is the registered one-hot of the current grant.
  assign clr = (state == ST_BUSY && core_done_i) ? core_id_o : '0;

  // A capture coinciding with the clear of the same slot wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= '0;
      slot    <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (P_strobe_i[k] && (!pending[k] || clr[k])) begin
          slot[k].addr     <= P_addr_i[k*XLEN +: XLEN];
          slot[k].rw       <= P_rw_i[k];
          slot[k].data     <= P_data_i[k*CLSIZE +: CLSIZE];
          slot[k].is_amo   <= P_is_amo_i[k];
          slot[k].amo_type <= P_amo_type_i[k*AMO_TYPE_W +: AMO_TYPE_W];
          pending[k]       <= 1'b1;
        end else if (clr[k]) begin
          pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= ST_IDLE;
      g               <= '0;
      last_grant      <= LW'(N-1);
      P_done_o        <= '0;
      P_data_o        <= '0;
      core_id_o       <= '0;
      core_strobe_o   <= 1'b0;
      core_addr_o     <= '0;
      core_rw_o       <= 1'b0;
      core_data_o     <= '0;
      core_is_amo_o   <= 1'b0;
      core_amo_type_o <= '0;
    end else begin
      P_done_o <= '0;
      case (state)
        ST_IDLE: if (|pending) begin
          g               <= pick_idx;
          core_id_o       <= pick_oh;
          core_addr_o     <= slot[pick_idx].addr;
          core_rw_o       <= slot[pick_idx].rw;
          core_data_o     <= slot[pick_idx].data;
          core_is_amo_o   <= slot[pick_idx].is_amo;
          core_amo_type_o <= slot[pick_idx].amo_type;
          core_strobe_o   <= 1'b1;
          state           <= ST_ISSUE;
        end
        ST_ISSUE: begin
          core_strobe_o <= 1'b0;
          state         <= ST_BUSY;
        end
        ST_BUSY: if (core_done_i) begin
          P_data_o   <= core_data_i;
          P_done_o   <= core_id_o;
          last_grant <= g;
          state      <= ST_GAP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amo_core_arbiter.sv
// Directed bench for amo_core_arbiter; the bench plays both cores and the atomic unit.
module tb_amo_core_arbiter;
  localparam int N = 2, XLEN = 32, CLSIZE = 64;

  logic              clk_i = 1'b0, rst_ni = 1'b0;
  logic [N-1:0]      P_strobe_i = '0, P_rw_i = '0, P_is_amo_i = '0;
  logic [N*XLEN-1:0] P_addr_i = '0;
  logic [N*CLSIZE-1:0] P_data_i = '0;
  logic [N*5-1:0]    P_amo_type_i = '0;
  logic [N-1:0]      P_done_o, core_id_o;
  logic [CLSIZE-1:0] P_data_o, core_data_o, core_data_i = '0;
  logic              core_strobe_o, core_rw_o, core_is_amo_o, core_done_i = 1'b0;
  logic [XLEN-1:0]   core_addr_o;
  logic [4:0]        core_amo_type_o;

  int nvec = 0, nerr = 0, nstrb, ndone, bad;

  amo_core_arbiter #(.N(N), .XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .P_strobe_i(P_strobe_i), .P_addr_i(P_addr_i), .P_rw_i(P_rw_i), .P_data_i(P_data_i),
    .P_is_amo_i(P_is_amo_i), .P_amo_type_i(P_amo_type_i),
    .P_done_o(P_done_o), .P_data_o(P_data_o),
    .core_id_o(core_id_o), .core_strobe_o(core_strobe_o), .core_addr_o(core_addr_o),
    .core_rw_o(core_rw_o), .core_data_o(core_data_o), .core_is_amo_o(core_is_amo_o),
    .core_amo_type_o(core_amo_type_o), .core_done_i(core_done_i), .core_data_i(core_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic req(input int k, input logic [31:0] a, input logic rw,
                     input logic [63:0] d, input logic amo, input logic [4:0] t);
    P_addr_i[k*XLEN +: XLEN]     = a;
    P_rw_i[k]                    = rw;
    P_data_i[k*CLSIZE +: CLSIZE] = d;
    P_is_amo_i[k]                = amo;
    P_amo_type_i[k*5 +: 5]       = t;
    P_strobe_i[k]                = 1'b1;
  endtask

  task automatic go();
    tick(); P_strobe_i = '0;
  endtask

  // Downstream completes 'lat' cycles after the strobe; P_done_o is then visible.
  task automatic serve(input int lat, input logic [63:0] d);
    repeat (lat) tick();
    core_done_i = 1'b1; core_data_i = d;
    tick();
    core_done_i = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_strobe", core_strobe_o, 0);
    chk("rst_id", core_id_o, 0);
    chk("rst_done", P_done_o, 0);
    chk("rst_pdata", P_data_o, 0);
    chk("rst_addr", core_addr_o, 0);
    rst_ni = 1'b1;
    tick();

    // simultaneous pair straight out of reset: core0 first
    req(0, 32'h1000, 1'b1, 64'h11, 1'b0, 5'h1f);
    req(1, 32'h2000, 1'b0, 64'h22, 1'b1, 5'h03);
    go();
    chk("sim_early", core_strobe_o, 0);
    tick();
    chk("sim_s0", core_strobe_o, 1);
    chk("sim_id0", core_id_o, 2'b01);
    chk("sim_addr0", core_addr_o, 32'h1000);
    chk("sim_rw0", core_rw_o, 1);
    chk("sim_wdata0", core_data_o, 64'h11);
    serve(3, 64'hC0);
    chk("sim_done0", P_done_o, 2'b01);
    chk("sim_pdata0", P_data_o, 64'hC0);
    tick();
    chk("sim_done0_1cyc", P_done_o, 0);
    chk("sim_gap", core_strobe_o, 0);
    tick();
    chk("sim_s1", core_strobe_o, 1);
    chk("sim_id1", core_id_o, 2'b10);
    chk("sim_addr1", core_addr_o, 32'h2000);
    chk("sim_amo1", core_is_amo_o, 1);
    chk("sim_type1", core_amo_type_o, 5'h03);
    serve(2, 64'hC1);
    chk("sim_done1", P_done_o, 2'b10);
    chk("sim_pdata1", P_data_o, 64'hC1);
    tick(); tick();

    // single core0 read
    req(0, 32'h8000_0040, 1'b0, 64'h0, 1'b0, 5'h1f);
    go();
    chk("one_early", core_strobe_o, 0);
    tick();
    chk("one_strobe", core_strobe_o, 1);
    chk("one_id", core_id_o, 2'b01);
    chk("one_addr", core_addr_o, 32'h8000_0040);
    tick();
    chk("one_strobe_1cyc", core_strobe_o, 0);
    serve(4, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("one_done", P_done_o, 2'b01);
    chk("one_pdata", P_data_o, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();
    chk("one_done_1cyc", P_done_o, 0);
    chk("one_pdata_hold", P_data_o, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();

    // pair again after a core0 grant: core1 first
    req(0, 32'h3000, 1'b0, 64'h0, 1'b0, 5'h1f);
    req(1, 32'h4000, 1'b0, 64'h0, 1'b0, 5'h1f);
    go(); tick();
    chk("rep_id1", core_id_o, 2'b10);
    chk("rep_addr1", core_addr_o, 32'h4000);
    serve(1, 64'hD1);
    chk("rep_done1", P_done_o, 2'b10);
    tick(); tick();
    chk("rep_s0", core_strobe_o, 1);
    chk("rep_id0", core_id_o, 2'b01);
    chk("rep_addr0", core_addr_o, 32'h3000);
    serve(1, 64'hD0);
    chk("rep_done0", P_done_o, 2'b01);
    tick(); tick();

    // AMO hold over a 12-cycle downstream window
    req(1, 32'h100, 1'b0, 64'h5, 1'b1, 5'h00);
    go(); tick();
    chk("amo_strobe", core_strobe_o, 1);
    chk("amo_id", core_id_o, 2'b10);
    nstrb = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (core_is_amo_o !== 1'b1 || core_amo_type_o !== 5'h00 || core_addr_o !== 32'h100 ||
          core_data_o !== 64'h5) bad++;
      tick();
      nstrb += int'(core_strobe_o);
    end
    chk("amo_hold", bad, 0);
    chk("amo_extra_strobes", nstrb, 0);
    core_done_i = 1'b1; core_data_i = 64'h77;
    tick(); core_done_i = 1'b0;
    chk("amo_done", P_done_o, 2'b10);
    chk("amo_pdata", P_data_o, 64'h77);
    chk("amo_hold_gap", core_is_amo_o, 1);
    tick(); tick();

    // starvation: core0 re-requests at each done, core1 must get in
    req(0, 32'h500, 1'b0, 64'h0, 1'b0, 5'h1f);
    go();
    req(1, 32'h600, 1'b0, 64'h0, 1'b0, 5'h1f);
    go();
    chk("stv_id0", core_id_o, 2'b01);
    serve(2, 64'hE0);
    chk("stv_done0", P_done_o, 2'b01);
    req(0, 32'h504, 1'b0, 64'h0, 1'b0, 5'h1f);
    go(); tick();
    chk("stv_s1", core_strobe_o, 1);
    chk("stv_id1", core_id_o, 2'b10);
    chk("stv_addr1", core_addr_o, 32'h600);
    serve(2, 64'hE1);
    chk("stv_done1", P_done_o, 2'b10);
    tick(); tick();
    chk("stv_id0b", core_id_o, 2'b01);
    chk("stv_addr0b", core_addr_o, 32'h504);
    serve(1, 64'hE2);
    chk("stv_done0b", P_done_o, 2'b01);
    tick(); tick();

    // duplicate strobe from core0 is dropped
    req(0, 32'h10, 1'b0, 64'h0, 1'b0, 5'h1f);
    go();
    req(0, 32'h20, 1'b0, 64'h0, 1'b0, 5'h1f);
    go();
    chk("dup_strobe", core_strobe_o, 1);
    chk("dup_addr", core_addr_o, 32'h10);
    serve(2, 64'hF0);
    chk("dup_done", P_done_o, 2'b01);
    nstrb = 0; ndone = 0;
    repeat (6) begin
      tick();
      nstrb += int'(core_strobe_o);
      ndone += int'(|P_done_o);
    end
    chk("dup_no_reissue", nstrb, 0);
    chk("dup_one_done", ndone, 0);

    // asynchronous reset while Busy
    req(0, 32'h700, 1'b1, 64'h99, 1'b1, 5'h0a);
    go(); tick(); tick();
    chk("ar_busy_addr", core_addr_o, 32'h700);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_addr", core_addr_o, 0);
    chk("ar_id", core_id_o, 0);
    chk("ar_amo", core_is_amo_o, 0);
    chk("ar_type", core_amo_type_o, 0);
    chk("ar_rw", core_rw_o, 0);
    chk("ar_wdata", core_data_o, 0);
    chk("ar_pdata", P_data_o, 0);
    tick();
    rst_ni = 1'b1;
    nstrb = 0; ndone = 0;
    for (int i = 0; i < 8; i++) begin
      core_done_i = (i == 1);
      core_data_i = 64'hBAD;
      tick();
      nstrb += int'(core_strobe_o);
      ndone += int'(|P_done_o);
    end
    core_done_i = 1'b0;
    chk("ar_no_done", ndone, 0);
    chk("ar_no_strobe", nstrb, 0);
    chk("ar_pdata_after", P_data_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
